// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding memory access, byte-lane steering and load extension.
// Latency: request to mem_req 1 cycle; load ack to writeback 1 cycle; req_ready low while busy.
package rv32i_pkg;
  typedef enum logic [5:0] {
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
    INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_FENCE, INSTR_ECALL, INSTR_EBREAK, INSTR_ILLEGAL
  } rv32i_instr_e;
endpackage

module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  rv32i_instr_e instr,
  input  logic [31:0]  addr,
  input  logic [31:0]  store_data,
  input  logic [4:0]   rd,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [31:0]  wb_data,
  output logic         err_misaligned,
  output logic         err_timeout,
  output logic [31:0]  err_addr
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e       r_state;
  state_e       w_state_nxt;
  rv32i_instr_e r_instr;
  logic [31:0]  r_addr;
  logic [4:0]   r_rd;
  logic [CW-1:0] r_cnt;

  logic         r_mem_we;
  logic [31:0]  r_mem_addr;
  logic [31:0]  r_mem_wdata;
  logic [3:0]   r_mem_be;
  logic         r_wb_valid;
  logic [4:0]   r_wb_rd;
  logic [31:0]  r_wb_data;
  logic         r_err_mis;
  logic         r_err_tmo;
  logic [31:0]  r_err_addr;

  logic         w_is_ls;
  logic         w_is_load;
  logic         w_misal;
  logic         w_accept;
  logic         w_tmo_hit;
  logic         w_ack_load;
  logic         w_timeout;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic [7:0]   w_byte;
  logic [15:0]  w_half;
  logic [31:0]  w_load_data;

  always_comb begin
    w_is_ls   = instr inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
                              INSTR_SB, INSTR_SH, INSTR_SW};
    w_is_load = instr inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    w_misal   = 1'b0;
    case (instr)
      INSTR_LH, INSTR_LHU, INSTR_SH: w_misal = addr[0];
      INSTR_LW, INSTR_SW:            w_misal = |addr[1:0];
      default:                       w_misal = 1'b0;
    endcase
    w_accept  = req_valid && (r_state == S_IDLE) && w_is_ls;
  end

  // Store lanes are formed from the live inputs and captured at acceptance.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (instr)
      INSTR_SB: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      INSTR_SH: begin
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = store_data;
      end
    endcase
  end

  always_comb begin
    w_byte      = 8'(mem_rdata >> {r_addr[1:0], 3'b000});
    w_half      = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_load_data = mem_rdata;
    case (r_instr)
      INSTR_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      INSTR_LBU: w_load_data = {24'd0, w_byte};
      INSTR_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      INSTR_LHU: w_load_data = {16'd0, w_half};
      default:   w_load_data = mem_rdata;
    endcase
  end

  // r_cnt holds the number of completed ACCESS cycles; the last allowed cycle is TIMEOUT-1.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_ack_load  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_misal) w_state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        if (mem_ack) begin
          if (r_instr inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU}) begin
            w_state_nxt = S_RESP;
            w_ack_load  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_instr     <= INSTR_LW;
      r_addr      <= 32'd0;
      r_rd        <= 5'd0;
      r_cnt       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_wb_data   <= 32'd0;
      r_err_mis   <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_err_addr  <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_mis  <= w_accept && w_misal;
      r_err_tmo  <= w_timeout;
      r_wb_valid <= w_ack_load && (r_rd != 5'd0);
      if ((r_state == S_ACCESS) && (w_state_nxt == S_ACCESS)) r_cnt <= r_cnt + 1'b1;
      else                                                    r_cnt <= '0;
      if (w_accept && !w_misal) begin
        r_instr     <= instr;
        r_addr      <= addr;
        r_rd        <= rd;
        r_mem_we    <= !w_is_load;
        r_mem_addr  <= {addr[31:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_be    <= w_be;
      end
      if (w_accept && w_misal) r_err_addr <= addr;
      else if (w_timeout)      r_err_addr <= r_addr;
      if (w_ack_load && (r_rd != 5'd0)) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_load_data;
      end
    end
  end

  assign req_ready      = (r_state == S_IDLE);
  assign mem_req        = (r_state == S_ACCESS);
  assign mem_we         = r_mem_we && (r_state == S_ACCESS);
  assign mem_addr       = r_mem_addr;
  assign mem_wdata      = r_mem_wdata;
  assign mem_be         = r_mem_be;
  assign wb_valid       = r_wb_valid;
  assign wb_rd          = r_wb_rd;
  assign wb_data        = r_wb_data;
  assign err_misaligned = r_err_mis;
  assign err_timeout    = r_err_tmo;
  assign err_addr       = r_err_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized transactions vs a behavioural model.
module tb_load_store_unit;
  import rv32i_pkg::*;

  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  rv32i_instr_e instr;
  logic [31:0]  addr;
  logic [31:0]  store_data;
  logic [4:0]   rd;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_be;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         wb_valid;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
  logic         err_misaligned;
  logic         err_timeout;
  logic [31:0]  err_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .instr(instr), .addr(addr), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout), .err_addr(err_addr)
  );

  // ---------------- behavioural model ----------------
  function automatic bit is_load(input rv32i_instr_e i);
    return (i == INSTR_LB) || (i == INSTR_LH) || (i == INSTR_LW) ||
           (i == INSTR_LBU) || (i == INSTR_LHU);
  endfunction

  function automatic bit exp_misal(input rv32i_instr_e i, input logic [31:0] a);
    int sz;
    sz = 1;
    if (i == INSTR_LH || i == INSTR_LHU || i == INSTR_SH) sz = 2;
    if (i == INSTR_LW || i == INSTR_SW) sz = 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] exp_be(input rv32i_instr_e i, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (i == INSTR_SB) return 4'(1 << off);
    if (i == INSTR_SH) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input rv32i_instr_e i, input logic [31:0] d);
    if (i == INSTR_SB) return (d % 256) * 32'h0101_0101;
    if (i == INSTR_SH) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input rv32i_instr_e i, input logic [31:0] a,
                                           input logic [31:0] w);
    longint v;
    int off;
    off = int'(a % 4);
    if (i == INSTR_LB || i == INSTR_LBU) begin
      v = longint'((w / (32'd1 << (8 * off))) % 256);
      if (i == INSTR_LB && v >= 128) v = v - 256;
    end else if (i == INSTR_LH || i == INSTR_LHU) begin
      v = longint'((w / (32'd1 << (8 * (off / 2) * 2))) % 65536);
      if (i == INSTR_LH && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return 32'(v);
  endfunction

  // ---------------- tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready: req_ready=%b after %0d cycles, want 1", req_ready, n);
    end
  endtask

  // ack_at: ACCESS cycle number (1-based) carrying mem_ack; 0 means never.
  task automatic run_txn(input rv32i_instr_e ins, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] r, input int ack_at, input logic [31:0] rdat);
    bit done;
    bit acked;
    int k;
    wait_ready();
    req_valid = 1'b1; instr = ins; addr = a; store_data = sd; rd = r;
    tick();
    req_valid = 1'b0; instr = INSTR_SW; addr = $urandom; store_data = $urandom; rd = 5'($urandom);
    if (exp_misal(ins, a)) begin
      n_vec++;
      if (mem_req !== 1'b0 || err_misaligned !== 1'b1 || err_addr !== a || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL misalign %s a=%h: req=%b mis=%b eaddr=%h rdy=%b, want 0 1 %h 1",
                 ins.name(), a, mem_req, err_misaligned, err_addr, req_ready, a);
      end
      tick();
      n_vec++;
      if (err_misaligned !== 1'b0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL misalign_pulse: mis=%b req=%b, want 0 0", err_misaligned, mem_req);
      end
      return;
    end
    done = 0; acked = 0; k = 1;
    while (!done) begin
      n_vec++;
      if (mem_req !== 1'b1 || mem_addr !== (a - (a % 4)) || mem_we !== !is_load(ins) ||
          mem_be !== exp_be(ins, a) || req_ready !== 1'b0 || err_misaligned !== 1'b0) begin
        n_err++;
        $display("FAIL access %s k=%0d: req=%b addr=%h we=%b be=%b rdy=%b, want 1 %h %b %b 0",
                 ins.name(), k, mem_req, mem_addr, mem_we, mem_be, req_ready,
                 a - (a % 4), !is_load(ins), exp_be(ins, a));
      end
      if (!is_load(ins)) begin
        n_vec++;
        if (mem_wdata !== exp_wdata(ins, sd)) begin
          n_err++;
          $display("FAIL wdata %s: got %h want %h", ins.name(), mem_wdata, exp_wdata(ins, sd));
        end
      end
      if (k == ack_at) begin
        mem_ack = 1'b1; mem_rdata = rdat;
      end else begin
        mem_rdata = $urandom;
      end
      tick();
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (k == ack_at) begin
        acked = 1; done = 1;
      end else if (k == TMO) begin
        done = 1;
      end
      k++;
    end
    if (!acked) begin
      n_vec++;
      if (mem_req !== 1'b0 || err_timeout !== 1'b1 || err_addr !== a ||
          req_ready !== 1'b1 || wb_valid !== 1'b0) begin
        n_err++;
        $display("FAIL timeout %s: req=%b tmo=%b eaddr=%h rdy=%b wbv=%b, want 0 1 %h 1 0",
                 ins.name(), mem_req, err_timeout, err_addr, req_ready, wb_valid, a);
      end
      tick();
      n_vec++;
      if (err_timeout !== 1'b0) begin
        n_err++;
        $display("FAIL timeout_pulse: tmo=%b want 0", err_timeout);
      end
    end else if (!is_load(ins)) begin
      n_vec++;
      if (mem_req !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0 || err_timeout !== 1'b0) begin
        n_err++;
        $display("FAIL store_done %s: req=%b rdy=%b wbv=%b tmo=%b, want 0 1 0 0",
                 ins.name(), mem_req, req_ready, wb_valid, err_timeout);
      end
    end else begin
      n_vec++;
      if (mem_req !== 1'b0 || req_ready !== 1'b0 || wb_valid !== (r != 5'd0) || err_timeout !== 1'b0) begin
        n_err++;
        $display("FAIL load_resp %s: req=%b rdy=%b wbv=%b tmo=%b, want 0 0 %b 0",
                 ins.name(), mem_req, req_ready, wb_valid, err_timeout, r != 5'd0);
      end
      if (r != 5'd0) begin
        n_vec++;
        if (wb_rd !== r || wb_data !== exp_load(ins, a, rdat)) begin
          n_err++;
          $display("FAIL load_data %s a=%h w=%h: rd=%0d data=%h, want %0d %h",
                   ins.name(), a, rdat, wb_rd, wb_data, r, exp_load(ins, a, rdat));
        end
      end
      tick();
      n_vec++;
      if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL load_end: wbv=%b rdy=%b, want 0 1", wb_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; instr = INSTR_ADD; addr = 32'hFFFF_FFFF;
    store_data = 32'hFFFF_FFFF; rd = 5'd31; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) tick();
    n_vec++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== 32'd0 || mem_be !== 4'd0 || wb_valid !== 1'b0 || wb_rd !== 5'd0 ||
        wb_data !== 32'd0 || err_misaligned !== 1'b0 || err_timeout !== 1'b0 || err_addr !== 32'd0) begin
      n_err++;
      $display("FAIL reset: rdy=%b req=%b we=%b addr=%h wd=%h be=%b wbv=%b rd=%0d wbd=%h mis=%b tmo=%b ea=%h, want 1 and all zero",
               req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_valid, wb_rd,
               wb_data, err_misaligned, err_timeout, err_addr);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_txn(INSTR_LW,  32'h0000_1000, 32'h0, 5'd1, 4, 32'hDEAD_BEEF);
    run_txn(INSTR_LB,  32'h0000_1003, 32'h0, 5'd2, 1, 32'h80FF_FF7F);
    run_txn(INSTR_LBU, 32'h0000_1003, 32'h0, 5'd3, 2, 32'h80FF_FF7F);
    run_txn(INSTR_LH,  32'h0000_1002, 32'h0, 5'd4, 1, 32'h8001_0000);
    run_txn(INSTR_SB,  32'h0000_2002, 32'h1234_56AB, 5'd5, 1, 32'h0);
    run_txn(INSTR_SH,  32'h0000_2002, 32'h1234_56AB, 5'd6, 2, 32'h0);
    run_txn(INSTR_SW,  32'h0000_2001, 32'h1234_56AB, 5'd7, 1, 32'h0);
    run_txn(INSTR_LH,  32'h0000_2003, 32'h0, 5'd8, 1, 32'h0);
  endtask

  task automatic test_timeout();
    run_txn(INSTR_LW, 32'h0000_4000, 32'h0, 5'd9, 0, 32'h0);
    run_txn(INSTR_LW, 32'h0000_4004, 32'h0, 5'd10, TMO, 32'hCAFE_F00D);
    run_txn(INSTR_SW, 32'h0000_4008, 32'h5555_AAAA, 5'd0, 0, 32'h0);
  endtask

  task automatic test_illegal();
    wait_ready();
    req_valid = 1'b1; instr = INSTR_ADDI; addr = 32'h0000_0001; rd = 5'd3;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (req_ready !== 1'b1 || mem_req !== 1'b0 || err_misaligned !== 1'b0 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL illegal: rdy=%b req=%b mis=%b wbv=%b, want 1 0 0 0",
               req_ready, mem_req, err_misaligned, wb_valid);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    req_valid = 1'b1; instr = INSTR_LW; addr = 32'h0000_3000; rd = 5'd12;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (mem_req !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_c1: req=%b want 1", mem_req);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0 || err_timeout !== 1'b0 ||
        err_misaligned !== 1'b0 || req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid: req=%b wbv=%b tmo=%b mis=%b rdy=%b, want 0 0 0 0 1",
               mem_req, wb_valid, err_timeout, err_misaligned, req_ready);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_vec++;
      if (mem_req !== 1'b0 || wb_valid !== 1'b0 || err_timeout !== 1'b0 || req_ready !== 1'b1) begin
        n_err++;
        $display("FAIL stray_ack c%0d: req=%b wbv=%b tmo=%b rdy=%b, want 0 0 0 1",
                 i, mem_req, wb_valid, err_timeout, req_ready);
      end
    end
    mem_ack = 1'b0;
    run_txn(INSTR_LW, 32'h0000_3004, 32'h0, 5'd0, 2, 32'h7777_8888);
  endtask

  task automatic test_random();
    rv32i_instr_e ops[8];
    rv32i_instr_e op;
    logic [31:0]  a;
    int           ack;
    ops = '{INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU, INSTR_SB, INSTR_SH, INSTR_SW};
    for (int n = 0; n < 60; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC | 32'($urandom_range(0, 1) * 2);
      ack = $urandom_range(1, TMO + 2);
      if (ack > TMO) ack = 0;
      run_txn(op, a, $urandom, 5'($urandom_range(0, 31)), ack, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 255, max cycles in ACCESS awaiting mem_ack before bus error; 0 disables timeout.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  execute stage offers an instruction
- req_ready  out  1  unit can accept a request
- instr  in  rv32i_instr_e  decoded instruction
- addr  in  32  effective address (ALU result, rs1+imm)
- store_data  in  32  rs2 value
- rd  in  5  destination register
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory completes request
- mem_rdata  in  32  read word, valid with mem_ack
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  32  extended load result
- err_misaligned  out  1  one-cycle misalignment pulse
- err_timeout  out  1  one-cycle bus-timeout pulse
- err_addr  out  32  faulting addr, valid with either error pulse
REQ-003 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = (state == IDLE).
REQ-005 SHALL accept on req_valid && req_ready only for LB, LH, LW, LBU, LHU, SB, SH, SW; other instr values: no state change, no outputs.
REQ-006 SHALL register instr, addr, store_data, rd on acceptance; later input changes have no effect.
REQ-007 SHALL detect misalignment at acceptance: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0; then no mem_req, err_misaligned=1 and err_addr=addr next cycle, remain IDLE.
REQ-008 SHALL on aligned acceptance at cycle T enter ACCESS, mem_req=1 from T+1, mem_addr={addr[31:2],2'b00}, mem_we=1 for stores, all mem_* stable until ack.
REQ-009 SHALL drive store lanes: SB be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}; SW be=4'b1111, wdata=data; loads be=4'b1111.
REQ-010 SHALL accept mem_ack in any ACCESS cycle, including first; mem_ack outside ACCESS ignored.
REQ-011 SHALL on store ack at cycle A drop mem_req and return to IDLE at A+1 (req_ready=1 at A+1).
REQ-012 SHALL on load ack at cycle A enter RESP at A+1 with wb_valid=1 for exactly one cycle, wb_rd=rd, wb_data extracted; IDLE at A+2.
REQ-013 SHALL extract: LB/LBU byte at lane addr[1:0]; LH/LHU half at addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW full word.
REQ-014 SHALL suppress wb_valid when rd==0; transaction still performed, RESP still occupies one cycle.
REQ-015 SHALL count ACCESS cycles; if count reaches TIMEOUT_CYCLES with no ack, drop mem_req, pulse err_timeout with err_addr, return to IDLE; ack in the final cycle wins over timeout.
REQ-016 SHALL keep wb_data, wb_rd, err_addr holding last value when strobes low; mem_be/mem_wdata don't-care when mem_req=0.

Reset
REQ-017 SHALL on rst force IDLE, counter 0, mem_req, mem_we, wb_valid, err_misaligned, err_timeout = 0; mem_addr, mem_wdata, mem_be, wb_rd, wb_data, err_addr = 0.
REQ-018 SHALL on rst mid-ACCESS or RESP abandon transaction: mem_req low next cycle, no wb_valid, no error pulse; req_ready=1 after reset released.

Verification
REQ-019 LW addr=0x1000, ack 3 cycles after mem_req, rdata=0xDEADBEEF -> mem_addr=0x1000, be=1111, wb_valid one cycle, wb_data=0xDEADBEEF.
REQ-020 LB addr=0x1003 rdata=0x80FF_FF7F / LBU same -> wb_data=0xFFFFFF80 / 0x00000080; LH addr=0x1002 rdata=0x8001_0000 -> 0xFFFF8001.
REQ-021 SB addr=0x2002 store_data=0x123456AB, ack same cycle -> mem_we=1, be=0100, wdata=0xABABABAB, req_ready=1 next cycle, no wb_valid.
REQ-022 SW addr=0x2001 -> no mem_req, err_misaligned pulse, err_addr=0x2001; LH addr=0x2003 likewise.
REQ-023 TIMEOUT_CYCLES=4, LW never acked -> mem_req high exactly 4 cycles, err_timeout pulse; second run with ack on 4th cycle -> wb_valid, no err_timeout.
REQ-024 rst asserted in ACCESS cycle 2 of LW -> mem_req=0 next cycle, no wb_valid, no error; following LW with rd=0 -> access performed, wb_valid stays 0.
